seq_mult_engine: RTL and testbench
==================================

Name: seq_mult_engine

Overview:
- Parametrised, multi-cycle successor to the 4-bit combinational multiplier datapath.
- An internal operand register file is loaded from a write port. A start/busy/done handshake launches one multiply of two register-file entries.
- A shift-add core performs one iteration per cycle. The 2*DATA_W-bit product is written to an internal result RAM at a destination address.
- The result RAM is read back through a registered read port. The block sits between the top-level control logic and the display/output register.

Parameters:
- DATA_W, 4, operand width in bits (>=2); product width is 2*DATA_W.
- RF_AW, 3, register-file address width; RF depth is 2**RF_AW.
- RAM_AW, 3, result-RAM address width; RAM depth is 2**RAM_AW.
- SIGNED, 0, 0 = unsigned operands and product; 1 = two's-complement operands and product.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high system reset.
- clear_mem  in  1  synchronous, active-high result-RAM clear, independent of rst.
- ld_en  in  1  register-file write enable.
- ld_adr  in  RF_AW  register-file write address.
- ld_data  in  DATA_W  register-file write data.
- start  in  1  request a multiply; sampled only in IDLE.
- ra1  in  RF_AW  register-file address of operand A; sampled with start.
- ra2  in  RF_AW  register-file address of operand B; sampled with start.
- dest_adr  in  RAM_AW  result-RAM write address; sampled with start.
- acc  in  1  accumulate request; sampled with start (see Optional Feature).
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse; the product has been written to the RAM.
- rd_adr  in  RAM_AW  result-RAM read address.
- result  out  2*DATA_W  registered RAM read data; 1-cycle latency.

Behaviour:
- Reset (rst):
  - FSM goes to IDLE; busy=0, done=0, result=0.
  - All RF entries and internal operand/accumulator/counter registers are cleared to 0.
  - The result RAM is not cleared by rst.
- clear_mem:
  - All RAM entries and result are cleared to 0 at the next edge.
  - An in-flight operation continues; its later write lands normally.
  - If clear_mem and a RAM write occur on the same edge, the clear wins.
  - rst and clear_mem together: both effects apply.
- RF writes:
  - Allowed in any state.
  - Operand fetch uses pre-edge RF contents, so a same-edge ld to an operand address is not seen by that operation.
- FSM states: IDLE, FETCH, MUL, WRITE, DONE.
  - IDLE: start=1 latches ra1, ra2, dest_adr, acc; next state FETCH. start is ignored in every other state (no queueing).
  - FETCH: loads multiplicand := RF[ra1], multiplier := RF[ra2], acc_reg := 0, cnt := 0; next state MUL.
  - MUL: one shift-add iteration per cycle for DATA_W cycles; exits to WRITE when cnt == DATA_W-1.
  - WRITE: writes the product (or the accumulated sum) to RAM[dest_adr]; next state DONE.
  - DONE: done=1 for this cycle only; next state IDLE.
- Latency: with start sampled at edge 0, the RAM write occurs at edge DATA_W+2 and done is high during the cycle after it. busy is high from edge 0 until edge DATA_W+3.
- Back-to-back: start held high is accepted again on the first IDLE cycle, so throughput is one operation per DATA_W+4 cycles.
- Arithmetic:
  - SIGNED=0: zero-extend both operands.
  - SIGNED=1: sign-extend the partial products; the final iteration subtracts rather than adds the multiplicand when the multiplier MSB is 1.
  - The product is exact in 2*DATA_W bits; no overflow is possible.
- Read port:
  - result <= RAM[rd_adr] every cycle.
  - A read and write to the same address on the same edge returns the old data.

Optional Feature:
- Macro: MULT_ACC_EN.
- Defined: if acc was latched =1, WRITE stores RAM[dest_adr] + product, truncated mod 2**(2*DATA_W). In signed mode the sum is two's-complement with wrap and no saturation.
- Undefined: the acc port is ignored and WRITE stores the product only.
- Latency is identical in both builds.

Decomposition:
- Package mult_pkg holds:
  - the FSM state enum (IDLE, FETCH, MUL, WRITE, DONE);
  - the default-width constants;
  - a function giving the product width from DATA_W.
- One sub-module, shift_add_core: takes DATA_W and SIGNED; has load and step inputs, an iteration counter and a last flag; outputs the product.
- The FSM, register file, RAM and read register stay in the top module.

Test Plan (DATA_W=4, RF_AW=3, RAM_AW=3 unless stated):
- Unsigned multiply: load RF[1]=7, RF[2]=9; start with ra1=1, ra2=2, dest_adr=3; then rd_adr=3 -> RAM[3]=0x3F; done pulses exactly once, 6 cycles after the start edge; busy spans 7 cycles.
- Max unsigned: RF[0]=15, RF[7]=15, dest_adr=7 -> 0xE1; also start held high through busy -> exactly one operation; the second is accepted in IDLE.
- SIGNED=1 build: RF[1]=4'h8 (-8), RF[2]=7 -> 8'hC8 (-56); RF[1]=-1, RF[2]=-1 -> 8'h01.
- MULT_ACC_EN defined: RAM[3]=0x3F; acc op with 2*3 -> 0x45; then RAM[5]=0xE1 with acc 15*15 -> 0xC2 (wrap). Repeat with the macro undefined -> 0x06 and 0xE1.
- clear_mem asserted mid-MUL -> RAM all 0 and result=0; the op still completes and RAM[dest] holds the product. clear_mem on the WRITE edge -> RAM[dest]=0.
- rst asserted mid-MUL -> busy=0 the next cycle, no done pulse, RF cleared, RAM contents unchanged; a subsequent operation is correct.

Source files
------------

// File: rtl/seq_mult_engine_pkg.sv
// Shared types and constants for the sequential multiply engine.
// FSM state encoding, default widths and the product-width helper.
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    MUL   = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_RF_AW  = 3;
  localparam int DEF_RAM_AW = 3;
  localparam int DEF_SIGNED = 0;

  function automatic int prod_w(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/seq_mult_engine_if.sv
// Control/data bus of seq_mult_engine: RF load port, start/busy/done
// handshake, result-RAM clear and the registered read port.
interface seq_mult_engine_if #(
  parameter int DATA_W = 4,
  parameter int RF_AW  = 3,
  parameter int RAM_AW = 3
);
  logic                            clear_mem;
  logic                            ld_en;
  logic [RF_AW-1:0]                ld_adr;
  logic [DATA_W-1:0]               ld_data;
  logic                            start;
  logic [RF_AW-1:0]                ra1;
  logic [RF_AW-1:0]                ra2;
  logic [RAM_AW-1:0]               dest_adr;
  logic                            acc;
  logic                            busy;
  logic                            done;
  logic [RAM_AW-1:0]               rd_adr;
  logic [mult_pkg::prod_w(DATA_W)-1:0] result;

  modport master (
    output clear_mem, ld_en, ld_adr, ld_data, start, ra1, ra2, dest_adr, acc, rd_adr,
    input  busy, done, result
  );

  modport slave (
    input  clear_mem, ld_en, ld_adr, ld_data, start, ra1, ra2, dest_adr, acc, rd_adr,
    output busy, done, result
  );
endinterface

// File: rtl/seq_mult_engine_shift_add_core.sv
// Shift-add multiplier core: one partial product per step, DATA_W steps.
// In signed mode the MSB partial product is subtracted (two's-complement weight).
module shift_add_core
  import mult_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SIGNED = DEF_SIGNED
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_load,
  input  logic                      i_step,
  input  logic [DATA_W-1:0]         i_mcand,
  input  logic [DATA_W-1:0]         i_mplier,
  output logic                      o_last,
  output logic [prod_w(DATA_W)-1:0] o_prod
);
  localparam int PW = prod_w(DATA_W);
  localparam int CW = $clog2(DATA_W);

  logic [PW-1:0]     r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [PW-1:0]     r_acc;
  logic [CW-1:0]     r_cnt;
  logic [PW-1:0]     w_ext;

  always_comb begin
    w_ext = {{DATA_W{1'b0}}, i_mcand};
    if (SIGNED != 0) w_ext = {{DATA_W{i_mcand[DATA_W-1]}}, i_mcand};
  end

  assign o_last = (r_cnt == CW'(DATA_W - 1));
  assign o_prod = r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_mcand  <= w_ext;
      r_mplier <= i_mplier;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_step) begin
      if (r_mplier[0]) begin
        if ((SIGNED != 0) && o_last) r_acc <= r_acc - r_mcand;
        else                         r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_mult_engine.sv
// Multi-cycle multiplier: operand RF, start/busy/done FSM, shift-add core,
// result RAM with registered read. Optional accumulate via MULT_ACC_EN.
module seq_mult_engine
  import mult_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RF_AW  = DEF_RF_AW,
  parameter int RAM_AW = DEF_RAM_AW,
  parameter int SIGNED = DEF_SIGNED
) (
  input  logic              clk,
  input  logic              rst,
  seq_mult_engine_if.slave  bus
);
  localparam int PW = prod_w(DATA_W);

  state_t             r_state, w_next;
  logic [DATA_W-1:0]  r_rf  [2**RF_AW];
  logic [PW-1:0]      r_mem [2**RAM_AW];
  logic [RF_AW-1:0]   r_ra1, r_ra2;
  logic [RAM_AW-1:0]  r_dest;
  logic [PW-1:0]      r_result;
  logic               w_load, w_step, w_we, w_last;
  logic [PW-1:0]      w_prod, w_wdata;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_we   = 1'b0;
    case (r_state)
      IDLE:  if (bus.start) w_next = FETCH;
      FETCH: begin w_load = 1'b1; w_next = MUL; end
      MUL:   begin w_step = 1'b1; if (w_last) w_next = WRITE; end
      WRITE: begin w_we = 1'b1; w_next = DONE; end
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign bus.busy   = (r_state != IDLE);
  assign bus.done   = (r_state == DONE);
  assign bus.result = r_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ra1  <= '0;
      r_ra2  <= '0;
      r_dest <= '0;
    end else if (r_state == IDLE && bus.start) begin
      r_ra1  <= bus.ra1;
      r_ra2  <= bus.ra2;
      r_dest <= bus.dest_adr;
    end
  end

`ifdef MULT_ACC_EN
  logic r_acc_req;
  always_ff @(posedge clk) begin
    if (rst)                               r_acc_req <= 1'b0;
    else if (r_state == IDLE && bus.start) r_acc_req <= bus.acc;
  end
  // Sum wraps mod 2**PW; identical bit pattern for signed and unsigned.
  assign w_wdata = r_acc_req ? (r_mem[r_dest] + w_prod) : w_prod;
`else
  logic w_unused_acc;
  assign w_unused_acc = bus.acc;
  assign w_wdata      = w_prod;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**RF_AW; i++) r_rf[i] <= '0;
    end else if (bus.ld_en) begin
      r_rf[bus.ld_adr] <= bus.ld_data;
    end
  end

  shift_add_core #(.DATA_W(DATA_W), .SIGNED(SIGNED)) u_core (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_mcand  (r_rf[r_ra1]),
    .i_mplier (r_rf[r_ra2]),
    .o_last   (w_last),
    .o_prod   (w_prod)
  );

  // RAM survives rst; only clear_mem wipes it, and it beats a same-edge write.
  always_ff @(posedge clk) begin
    if (bus.clear_mem) begin
      for (int i = 0; i < 2**RAM_AW; i++) r_mem[i] <= '0;
    end else if (w_we) begin
      r_mem[r_dest] <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clear_mem) r_result <= '0;
    else                      r_result <= r_mem[bus.rd_adr];
  end

endmodule

// File: tb/tb_seq_mult_engine.sv
// Directed bench for seq_mult_engine: an unsigned and a SIGNED=1 instance
// share one stimulus stream; expectations are hand-computed constants.
module tb_seq_mult_engine;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  seq_mult_engine_if #(.DATA_W(4), .RF_AW(3), .RAM_AW(3)) m_if ();
  seq_mult_engine_if #(.DATA_W(4), .RF_AW(3), .RAM_AW(3)) s_if ();

  assign s_if.clear_mem = m_if.clear_mem;
  assign s_if.ld_en     = m_if.ld_en;
  assign s_if.ld_adr    = m_if.ld_adr;
  assign s_if.ld_data   = m_if.ld_data;
  assign s_if.start     = m_if.start;
  assign s_if.ra1       = m_if.ra1;
  assign s_if.ra2       = m_if.ra2;
  assign s_if.dest_adr  = m_if.dest_adr;
  assign s_if.acc       = m_if.acc;
  assign s_if.rd_adr    = m_if.rd_adr;

  seq_mult_engine #(.DATA_W(4), .RF_AW(3), .RAM_AW(3), .SIGNED(0)) u_dut (
    .clk (clk), .rst (rst), .bus (m_if)
  );
  seq_mult_engine #(.DATA_W(4), .RF_AW(3), .RAM_AW(3), .SIGNED(1)) u_dut_s (
    .clk (clk), .rst (rst), .bus (s_if)
  );

`ifdef MULT_ACC_EN
  localparam logic [7:0] EXP_ACC1 = 8'h45;
  localparam logic [7:0] EXP_ACC2 = 8'hC2;
`else
  localparam logic [7:0] EXP_ACC1 = 8'h06;
  localparam logic [7:0] EXP_ACC2 = 8'hE1;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [2:0] a, input logic [3:0] d);
    m_if.ld_en = 1'b1; m_if.ld_adr = a; m_if.ld_data = d;
    tick();
    m_if.ld_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] ru, output logic [7:0] rs);
    m_if.rd_adr = a;
    tick();
    ru = m_if.result;
    rs = s_if.result;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!m_if.done && cyc < 20) begin
      tick();
      cyc++;
    end
    if (!m_if.done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic launch(input logic [2:0] a1, input logic [2:0] a2,
                        input logic [2:0] d, input logic ac);
    m_if.ra1 = a1; m_if.ra2 = a2; m_if.dest_adr = d; m_if.acc = ac;
    m_if.start = 1'b1;
    tick();
    m_if.start = 1'b0;
  endtask

  task automatic run(input logic [2:0] a1, input logic [2:0] a2,
                     input logic [2:0] d, input logic ac);
    int cyc;
    launch(a1, a2, d, ac);
    wait_done(cyc);
    if (m_if.done) chk("op_latency", cyc, 6);
    tick();
  endtask

  initial begin
    logic [7:0] ru, rs;
    int busy_n, done_n, done_at, cyc;
    logic b7, b8;

    rst = 1'b1;
    m_if.clear_mem = 1'b0; m_if.ld_en = 1'b0; m_if.ld_adr = '0; m_if.ld_data = '0;
    m_if.start = 1'b0; m_if.ra1 = '0; m_if.ra2 = '0; m_if.dest_adr = '0;
    m_if.acc = 1'b0; m_if.rd_adr = '0;
    tick(); tick();
    chk("rst_busy",   m_if.busy,   0);
    chk("rst_done",   m_if.done,   0);
    chk("rst_result", m_if.result, 0);
    rst = 1'b0;
    m_if.clear_mem = 1'b1;
    tick();
    m_if.clear_mem = 1'b0;
    chk("init_clear_result", m_if.result, 0);

    // 7*9 with cycle-accurate busy/done tracking
    ld(3'd1, 4'd7); ld(3'd2, 4'd9);
    launch(3'd1, 3'd2, 3'd3, 1'b0);
    busy_n = 0; done_n = 0; done_at = -1;
    for (int s = 0; s <= 10; s++) begin
      if (m_if.busy) busy_n++;
      if (m_if.done) begin done_n++; done_at = s; end
      tick();
    end
    chk("busy_span",  busy_n,  7);
    chk("done_count", done_n,  1);
    chk("done_at",    done_at, 6);
    rd(3'd3, ru, rs);
    chk("u_7x9", ru, 8'h3F);

    // 15*15 with start held: second op accepted only after IDLE returns
    ld(3'd0, 4'd15); ld(3'd7, 4'd15);
    m_if.ra1 = 3'd0; m_if.ra2 = 3'd7; m_if.dest_adr = 3'd7; m_if.acc = 1'b0;
    m_if.start = 1'b1;
    tick();
    done_n = 0; b7 = 1'b1; b8 = 1'b0;
    for (int s = 0; s <= 15; s++) begin
      if (m_if.done) done_n++;
      if (s == 7) b7 = m_if.busy;
      if (s == 8) begin b8 = m_if.busy; m_if.start = 1'b0; end
      tick();
    end
    chk("held_done_count", done_n, 2);
    chk("held_idle_gap",   b7, 0);
    chk("held_reaccept",   b8, 1);
    rd(3'd7, ru, rs);
    chk("u_15x15", ru, 8'hE1);

    // accumulate (macro-dependent expectations)
    ld(3'd3, 4'd2); ld(3'd4, 4'd3);
    run(3'd3, 3'd4, 3'd3, 1'b1);
    rd(3'd3, ru, rs);
    chk("acc_add", ru, EXP_ACC1);
    run(3'd0, 3'd7, 3'd5, 1'b0);
    rd(3'd5, ru, rs);
    chk("acc_base", ru, 8'hE1);
    run(3'd0, 3'd7, 3'd5, 1'b1);
    rd(3'd5, ru, rs);
    chk("acc_wrap", ru, EXP_ACC2);

    // signed vs unsigned on the same operands
    ld(3'd1, 4'h8); ld(3'd2, 4'd7);
    run(3'd1, 3'd2, 3'd0, 1'b0);
    rd(3'd0, ru, rs);
    chk("u_8x7",    ru, 8'h38);
    chk("s_m8x7",   rs, 8'hC8);
    ld(3'd1, 4'hF); ld(3'd2, 4'hF);
    run(3'd1, 3'd2, 3'd1, 1'b0);
    rd(3'd1, ru, rs);
    chk("u_15x15b", ru, 8'hE1);
    chk("s_m1xm1",  rs, 8'h01);

    // clear_mem mid-MUL: RAM wiped, op still lands
    m_if.rd_adr = 3'd7;
    launch(3'd3, 3'd4, 3'd6, 1'b0);
    tick(); tick();
    m_if.clear_mem = 1'b1;
    tick();
    m_if.clear_mem = 1'b0;
    chk("clr_result", m_if.result, 0);
    chk("clr_busy",   m_if.busy,   1);
    wait_done(cyc);
    tick();
    rd(3'd7, ru, rs);
    chk("clr_ram7", ru, 8'h00);
    rd(3'd6, ru, rs);
    chk("clr_op_lands", ru, 8'h06);

    // clear_mem on the WRITE edge beats the write
    launch(3'd0, 3'd7, 3'd6, 1'b0);
    tick(); tick(); tick(); tick(); tick();
    m_if.clear_mem = 1'b1;
    tick();
    m_if.clear_mem = 1'b0;
    chk("clrw_done", m_if.done, 1);
    tick();
    rd(3'd6, ru, rs);
    chk("clrw_ram6", ru, 8'h00);

    // rst mid-MUL: abort, RF cleared, RAM kept
    run(3'd0, 3'd7, 3'd2, 1'b0);
    rd(3'd2, ru, rs);
    chk("pre_rst_ram2", ru, 8'hE1);
    launch(3'd3, 3'd4, 3'd2, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy",   m_if.busy,   0);
    chk("rst_mid_result", m_if.result, 0);
    done_n = 0;
    for (int s = 0; s < 10; s++) begin
      if (m_if.done) done_n++;
      tick();
    end
    chk("rst_no_done", done_n, 0);
    rd(3'd2, ru, rs);
    chk("rst_ram_kept", ru, 8'hE1);
    run(3'd0, 3'd7, 3'd4, 1'b0);
    rd(3'd4, ru, rs);
    chk("rst_rf_cleared", ru, 8'h00);
    ld(3'd1, 4'd5); ld(3'd2, 4'd6);
    run(3'd1, 3'd2, 3'd1, 1'b0);
    rd(3'd1, ru, rs);
    chk("post_rst_5x6", ru, 8'h1E);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
